btb_set_assoc: RTL and testbench
================================

// Module: btb_set_assoc
// PURPOSE
//  Set-associative branch target buffer for the Fetch stage; successor to the direct-mapped BTB.
//  - Adds WAYS-way associativity, 2-bit saturating direction counters, round-robin replacement and FETCH_WIDTH chained slots.
//  - Adds a registered 1-cycle lookup and a global flush.
//  - Fetch supplies the lookup PC; Commit supplies resolved-branch updates.
// PARAMETERS
//  ADDR_WIDTH   32                      PC/target width
//  SETS         16                      number of sets, power of 2, >= 2
//  WAYS         2                       ways per set, power of 2, >= 1
//  FETCH_WIDTH  2                       chained predictions per lookup, >= 1
//  SET_W        $clog2(SETS)            derived set-index width
//  TAG_W        ADDR_WIDTH-SET_W-2      derived tag width
// PORTS
//  clk            in   1                      clock
//  rst            in   1                      asynchronous, active-high reset
//  lookup_valid   in   1                      Fetch lookup request
//  lookup_pc      in   ADDR_WIDTH             PC of fetch slot 0
//  resp_valid     out  1                      response valid (lookup_valid delayed 1 cycle)
//  resp_taken     out  FETCH_WIDTH            per-slot predicted-taken
//  resp_target    out  FETCH_WIDTH*ADDR_WIDTH per-slot next PC; slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//  update_valid   in   1                      Commit update strobe
//  update_pc      in   ADDR_WIDTH             resolved branch PC
//  update_taken   in   1                      resolved direction
//  update_target  in   ADDR_WIDTH             resolved target
//  flush          in   1                      synchronous invalidate of all entries
// BEHAVIOUR
//  - Index/tag: set = pc[SET_W+1:2]; tag = pc[ADDR_WIDTH-1:SET_W+2]; pc[1:0] ignored.
//  - Entry fields: valid, 2-bit ctr, tag, target.
//    - Hit: valid && tag match.
//    - At most one way hits; duplicate tags are never allocated.
//  - Slot chain, all combinational within the lookup cycle:
//    - slot0 address = lookup_pc; slot i address = slot i-1 next PC.
//    - slot i taken = hit && ctr[1].
//    - slot i next PC = taken ? entry.target : address+4, modulo 2^ADDR_WIDTH.
//  - Latency: results are registered.
//    - resp_* are valid the cycle after lookup_valid and hold until the next registered lookup.
//    - resp_valid=0 in any cycle without a lookup in the previous cycle.
//    - With lookup_valid=0, resp_taken/resp_target are don't-care.
//  - Reset: all entries invalid, ctr=2'b00, round-robin pointers 0.
//    - resp_valid=0, resp_taken=0, resp_target=0.
//    - Reset mid-lookup discards the pending response.
//  - Update (posedge, when update_valid):
//    - Hit, taken: ctr saturating +1 (max 2'b11); target <= update_target.
//    - Hit, not-taken: ctr saturating -1 (min 2'b00); entry stays valid; target unchanged.
//    - Miss, taken: allocate with ctr=2'b10, tag, target.
//      - Victim = lowest-index invalid way; otherwise rr_ptr[set].
//      - rr_ptr[set] increments (mod WAYS) only when a valid way is evicted.
//    - Miss, not-taken: no state change.
//  - Simultaneous lookup and update to the same set: lookup reads pre-update contents (read-before-write).
//  - flush: all valid bits cleared next edge; pointers reset to 0.
//    - flush has priority over a same-cycle update (update dropped).
//    - A same-cycle lookup still returns pre-flush contents.
// STRUCTURE
//  - bpu_pkg: btb_entry_t typedef (parametrised via localparams); ctr constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11; sat_inc/sat_dec functions.
//  - Sub-module btb_victim_sel: (valid vector, rr_ptr) -> victim way index. Purely combinational; rr_ptr storage stays in btb_set_assoc.
//  - Storage is flop arrays (async reset needed); no SRAM macro.
// TESTING
//  1 Reset, then lookup 0x100 (FETCH_WIDTH=2) -> next cycle resp_valid=1, taken=00, targets 0x104/0x108.
//  2 Update 0x100 taken->0x200, then lookup 0x100 -> slot0 taken target 0x200; slot1 looks up 0x200, not taken, target 0x204.
//  3 Hysteresis on 0x100 (ctr 10): taken -> 11; not-taken -> 10, still predicts taken; not-taken -> 01, predicts not taken, target 0x104.
//  4 Conflict (SETS=16, WAYS=2): allocate taken 0x100, 0x500, 0x900 (all set 0).
//    - Lookups: 0x100 misses (way0 evicted); 0x500 and 0x900 hit.
//    - Next allocation 0xD00 evicts 0x500.
//  5 Same cycle: update 0x100 taken->0x300 and lookup 0x100 -> old result; lookup one cycle later -> 0x300.
//  6 flush together with update 0x100 -> all lookups miss afterwards, including 0x100; async rst asserted mid-lookup -> resp_valid=0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-prediction types: BTB entry layout, 2-bit direction counter encodings
// and saturating counter helpers.
package bpu_pkg;

  localparam int BTB_ADDR_W = 32;
  localparam int BTB_SETS   = 16;
  localparam int BTB_SET_W  = $clog2(BTB_SETS);
  localparam int BTB_TAG_W  = BTB_ADDR_W - BTB_SET_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            ctr;
    logic [BTB_TAG_W-1:0]  tag;
    logic [BTB_ADDR_W-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement victim choice for one BTB set: lowest-index invalid way, else the
// set's round-robin pointer.
module btb_victim_sel #(
  parameter int WAYS = 2,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [WAY_W-1:0] rr_ptr,
  output logic [WAY_W-1:0] victim
);

  // Scanning downward lets the lowest invalid way win.
  always_comb begin
    victim = rr_ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB with 2-bit direction counters, round-robin replacement and
// FETCH_WIDTH chained prediction slots; lookup result is registered.
module btb_set_assoc
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int FETCH_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              lookup_valid,
  input  logic [ADDR_WIDTH-1:0]             lookup_pc,
  output logic                              resp_valid,
  output logic [FETCH_WIDTH-1:0]            resp_taken,
  output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] resp_target,
  input  logic                              update_valid,
  input  logic [ADDR_WIDTH-1:0]             update_pc,
  input  logic                              update_taken,
  input  logic [ADDR_WIDTH-1:0]             update_target,
  input  logic                              flush
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - SET_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]       valid_q  [SETS];
  logic [1:0]            ctr_q    [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q    [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] target_q [SETS][WAYS];
  logic [WAY_W-1:0]      rr_q     [SETS];

  // Lookup: each slot searches the array at the previous slot's next PC.
  logic [FETCH_WIDTH-1:0]            taken_c;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] target_c;
  logic [ADDR_WIDTH-1:0]             addr, nxt, hit_tgt;
  logic [SET_W-1:0]                  lk_set;
  logic [TAG_W-1:0]                  lk_tag;
  logic                              lk_hit;
  logic [1:0]                        lk_ctr;

  always_comb begin
    taken_c  = '0;
    target_c = '0;
    addr     = lookup_pc;
    nxt      = '0;
    lk_set   = '0;
    lk_tag   = '0;
    lk_hit   = 1'b0;
    lk_ctr   = CTR_SNT;
    hit_tgt  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lk_set  = addr[SET_W+1:2];
      lk_tag  = addr[ADDR_WIDTH-1:SET_W+2];
      lk_hit  = 1'b0;
      lk_ctr  = CTR_SNT;
      hit_tgt = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
          lk_hit  = 1'b1;
          lk_ctr  = ctr_q[lk_set][w];
          hit_tgt = target_q[lk_set][w];
        end
      end
      taken_c[i] = lk_hit && lk_ctr[1];
      nxt        = taken_c[i] ? hit_tgt : addr + ADDR_WIDTH'(4);
      target_c[i*ADDR_WIDTH +: ADDR_WIDTH] = nxt;
      addr = nxt;
    end
  end

  // Update-side tag match and victim selection.
  logic [SET_W-1:0] upd_set;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [WAY_W-1:0] upd_way;
  logic [WAY_W-1:0] victim;
  logic             evict_valid;
  logic             unused_pc_lsbs;

  assign upd_set        = update_pc[SET_W+1:2];
  assign upd_tag        = update_pc[ADDR_WIDTH-1:SET_W+2];
  assign evict_valid    = &valid_q[upd_set];
  assign unused_pc_lsbs = ^update_pc[1:0];

  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[upd_set][w] && tag_q[upd_set][w] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = WAY_W'(w);
      end
    end
  end

  btb_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid  (valid_q[upd_set]),
    .rr_ptr (rr_q[upd_set]),
    .victim (victim)
  );

  // Control state: valid bits, counters, replacement pointers. Flush beats update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= CTR_SNT;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (update_valid) begin
      if (upd_hit) begin
        ctr_q[upd_set][upd_way] <= update_taken ? sat_inc(ctr_q[upd_set][upd_way])
                                                : sat_dec(ctr_q[upd_set][upd_way]);
      end else if (update_taken) begin
        valid_q[upd_set][victim] <= 1'b1;
        ctr_q[upd_set][victim]   <= CTR_WT;
        if (evict_valid) rr_q[upd_set] <= (WAYS == 1) ? '0 : rr_q[upd_set] + WAY_W'(1);
      end
    end
  end

  // Tag/target payload needs no reset; it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!flush && update_valid && update_taken) begin
      if (upd_hit) begin
        target_q[upd_set][upd_way] <= update_target;
      end else begin
        tag_q[upd_set][victim]    <= upd_tag;
        target_q[upd_set][victim] <= update_target;
      end
    end
  end

  // Response stage: registered, holds until the next lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_taken  <= '0;
      resp_target <= '0;
    end else begin
      resp_valid <= lookup_valid;
      if (lookup_valid) begin
        resp_taken  <= taken_c;
        resp_target <= target_c;
      end
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (SETS=16, WAYS=2, FETCH_WIDTH=2): cold lookup,
// allocation, hysteresis, set conflicts, read-before-write, flush and async reset.
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        resp_valid;
  logic [1:0]  resp_taken;
  logic [63:0] resp_target;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = '0;
  logic        flush = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  wire [66:0] obs = {resp_valid, resp_taken, resp_target};

  btb_set_assoc #(.ADDR_WIDTH(32), .SETS(16), .WAYS(2), .FETCH_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .resp_valid    (resp_valid),
    .resp_taken    (resp_taken),
    .resp_target   (resp_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic lookup(input logic [31:0] pc);
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    @(negedge clk);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_taken  = tk;
    update_target = tgt;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (obs !== 67'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_lookup();
    logic [66:0] exp;
    lookup(32'h100);
    exp = {1'b1, 2'b00, 32'h108, 32'h104};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL cold_lookup: got %h, expected %h", obs, exp);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_resp_valid: got %b, expected 0", resp_valid);
    end
  endtask

  task automatic test_allocate_chain();
    logic [66:0] exp;
    update(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    exp = {1'b1, 2'b01, 32'h204, 32'h200};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL alloc_chain: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_hysteresis();
    logic [66:0] exp;
    update(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    exp = {1'b1, 2'b01, 32'h204, 32'h200};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL hyst_ctr11: got %h, expected %h", obs, exp);
    end
    update(32'h100, 1'b0, 32'hDEAD0);
    lookup(32'h100);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL hyst_ctr10: got %h, expected %h", obs, exp);
    end
    update(32'h100, 1'b0, 32'hDEAD0);
    lookup(32'h100);
    exp = {1'b1, 2'b00, 32'h108, 32'h104};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL hyst_ctr01: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] pcs  [6];
    logic [66:0] exps [6];
    pulse_reset();
    update(32'h100, 1'b1, 32'h200);
    update(32'h500, 1'b1, 32'h600);
    update(32'h900, 1'b1, 32'hA00);
    pcs[0] = 32'h100; exps[0] = {1'b1, 2'b00, 32'h108, 32'h104};
    pcs[1] = 32'h500; exps[1] = {1'b1, 2'b01, 32'h604, 32'h600};
    pcs[2] = 32'h900; exps[2] = {1'b1, 2'b01, 32'hA04, 32'hA00};
    pcs[3] = 32'h500; exps[3] = {1'b1, 2'b00, 32'h508, 32'h504};
    pcs[4] = 32'hD00; exps[4] = {1'b1, 2'b01, 32'hE04, 32'hE00};
    pcs[5] = 32'h900; exps[5] = {1'b1, 2'b01, 32'hA04, 32'hA00};
    for (int i = 0; i < 6; i++) begin
      if (i == 3) update(32'hD00, 1'b1, 32'hE00);
      lookup(pcs[i]);
      tests_run++;
      if (obs !== exps[i]) begin
        tests_failed++;
        $display("FAIL conflict[%0d] pc=%h: got %h, expected %h", i, pcs[i], obs, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] exp;
    pulse_reset();
    update(32'h100, 1'b1, 32'h200);
    @(negedge clk);
    update_valid  = 1'b1;
    update_pc     = 32'h100;
    update_taken  = 1'b1;
    update_target = 32'h300;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h100;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    exp = {1'b1, 2'b01, 32'h204, 32'h200};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL rbw_same_cycle: got %h, expected %h", obs, exp);
    end
    lookup(32'h100);
    exp = {1'b1, 2'b01, 32'h304, 32'h300};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL rbw_next_cycle: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_flush();
    logic [66:0] exp;
    update(32'h500, 1'b1, 32'h600);
    @(negedge clk);
    flush         = 1'b1;
    update_valid  = 1'b1;
    update_pc     = 32'h100;
    update_taken  = 1'b1;
    update_target = 32'h400;
    lookup_valid  = 1'b1;
    lookup_pc     = 32'h100;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    update_valid = 1'b0;
    lookup_valid = 1'b0;
    exp = {1'b1, 2'b01, 32'h304, 32'h300};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_same_cycle_lookup: got %h, expected %h", obs, exp);
    end
    lookup(32'h100);
    exp = {1'b1, 2'b00, 32'h108, 32'h104};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_miss_100: got %h, expected %h", obs, exp);
    end
    lookup(32'h500);
    exp = {1'b1, 2'b00, 32'h508, 32'h504};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_miss_500: got %h, expected %h", obs, exp);
    end
    @(negedge clk);
    flush         = 1'b1;
    update_valid  = 1'b1;
    update_pc     = 32'h900;
    update_taken  = 1'b1;
    update_target = 32'hA00;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    update_valid = 1'b0;
    lookup(32'h900);
    exp = {1'b1, 2'b00, 32'h908, 32'h904};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL flush_drops_alloc: got %h, expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_lookup();
    logic [66:0] exp;
    update(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== 67'd0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got %h, expected 0", obs);
    end
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_discards_lookup: got %b, expected 0", resp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    lookup(32'h100);
    exp = {1'b1, 2'b00, 32'h108, 32'h104};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_clears_entries: got %h, expected %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_cold_lookup();
    test_allocate_chain();
    test_hysteresis();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid_lookup();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
